// File: rtl/decode_stage.sv
// RV64I instruction-decode stage: decodes fetched bits into a registered ID/EX bundle.
// Define DECODE_LOADUSE_EN to insert load-use bubbles and count stall cycles.
module decode_stage #(
    parameter int unsigned REGISTER_WIDTH    = 64,
    parameter int unsigned ADDRESS_WIDTH     = 64,
    parameter int unsigned INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] in_instruction_bits,
    input  logic [ADDRESS_WIDTH-1:0]     in_pcplus1,
    input  logic                         in_flush,
    input  logic                         in_next_ready,
    output logic                         out_fetch_enable,
    output logic [4:0]                   out_rs1_addr,
    output logic [4:0]                   out_rs2_addr,
    input  logic [REGISTER_WIDTH-1:0]    in_rs1_data,
    input  logic [REGISTER_WIDTH-1:0]    in_rs2_data,
    output logic                         out_valid,
    output logic [ADDRESS_WIDTH-1:0]     out_pc,
    output logic [ADDRESS_WIDTH-1:0]     out_pcplus1,
    output logic [REGISTER_WIDTH-1:0]    out_rs1_val,
    output logic [REGISTER_WIDTH-1:0]    out_rs2_val,
    output logic [REGISTER_WIDTH-1:0]    out_imm,
    output logic [4:0]                   out_rd,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [3:0]                   out_opclass,
    output logic [2:0]                   out_funct3,
    output logic [6:0]                   out_funct7,
    output logic                         out_illegal,
    output logic                         out_syscall,
    output logic [31:0]                  out_stall_count
);

    localparam logic [3:0] OPC_ILLEGAL = 4'd0;
    localparam logic [3:0] OPC_LUI     = 4'd1;
    localparam logic [3:0] OPC_AUIPC   = 4'd2;
    localparam logic [3:0] OPC_JAL     = 4'd3;
    localparam logic [3:0] OPC_JALR    = 4'd4;
    localparam logic [3:0] OPC_BRANCH  = 4'd5;
    localparam logic [3:0] OPC_LOAD    = 4'd6;
    localparam logic [3:0] OPC_STORE   = 4'd7;
    localparam logic [3:0] OPC_OPIMM   = 4'd8;
    localparam logic [3:0] OPC_OP      = 4'd9;
    localparam logic [3:0] OPC_OPIMM32 = 4'd10;
    localparam logic [3:0] OPC_OP32    = 4'd11;
    localparam logic [3:0] OPC_SYSTEM  = 4'd12;
    localparam logic [3:0] OPC_FENCE   = 4'd13;

    logic [INSTRUCTION_WIDTH-1:0] ins;
    logic [4:0]                   dec_rs1;
    logic [4:0]                   dec_rs2;
    logic [3:0]                   dec_opclass;
    logic [REGISTER_WIDTH-1:0]    dec_imm;
    logic [REGISTER_WIDTH-1:0]    imm_i;
    logic [REGISTER_WIDTH-1:0]    imm_s;
    logic [REGISTER_WIDTH-1:0]    imm_b;
    logic [REGISTER_WIDTH-1:0]    imm_u;
    logic [REGISTER_WIDTH-1:0]    imm_j;
    logic                         hazard;

    assign ins          = in_instruction_bits;
    assign dec_rs1      = ins[19:15];
    assign dec_rs2      = ins[24:20];
    assign out_rs1_addr = dec_rs1;
    assign out_rs2_addr = dec_rs2;

    // All immediate formats sign-extend from instruction bit 31.
    assign imm_i = REGISTER_WIDTH'($signed(ins[31:20]));
    assign imm_s = REGISTER_WIDTH'($signed({ins[31:25], ins[11:7]}));
    assign imm_b = REGISTER_WIDTH'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    assign imm_u = REGISTER_WIDTH'($signed({ins[31:12], 12'b0}));
    assign imm_j = REGISTER_WIDTH'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));

    always_comb begin
        dec_opclass = OPC_ILLEGAL;
        case (ins[6:0])
            7'b0110111: dec_opclass = OPC_LUI;
            7'b0010111: dec_opclass = OPC_AUIPC;
            7'b1101111: dec_opclass = OPC_JAL;
            7'b1100111: dec_opclass = OPC_JALR;
            7'b1100011: dec_opclass = OPC_BRANCH;
            7'b0000011: dec_opclass = OPC_LOAD;
            7'b0100011: dec_opclass = OPC_STORE;
            7'b0010011: dec_opclass = OPC_OPIMM;
            7'b0110011: dec_opclass = OPC_OP;
            7'b0011011: dec_opclass = OPC_OPIMM32;
            7'b0111011: dec_opclass = OPC_OP32;
            7'b1110011: dec_opclass = OPC_SYSTEM;
            7'b0001111: dec_opclass = OPC_FENCE;
            default:    dec_opclass = OPC_ILLEGAL;
        endcase
    end

    always_comb begin
        dec_imm = '0;
        case (dec_opclass)
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_SYSTEM: dec_imm = imm_i;
            OPC_STORE:          dec_imm = imm_s;
            OPC_BRANCH:         dec_imm = imm_b;
            OPC_LUI, OPC_AUIPC: dec_imm = imm_u;
            OPC_JAL:            dec_imm = imm_j;
            default:            dec_imm = '0;
        endcase
    end

`ifdef DECODE_LOADUSE_EN
    logic uses_rs1;
    logic uses_rs2;

    assign uses_rs1 = !(dec_opclass inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE, OPC_SYSTEM});
    assign uses_rs2 = dec_opclass inside {OPC_BRANCH, OPC_STORE, OPC_OP, OPC_OP32};

    // Load in ID/EX whose destination the incoming instruction reads.
    assign hazard = out_valid && (out_opclass == OPC_LOAD) && (out_rd != 5'd0) &&
                    ((uses_rs1 && (dec_rs1 == out_rd)) || (uses_rs2 && (dec_rs2 == out_rd)));
`else
    // Execute forwards load data, so no bubble is ever needed.
    assign hazard = 1'b0;
`endif

    assign out_fetch_enable = in_next_ready && !hazard && !in_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid       <= 1'b0;
            out_pc          <= '0;
            out_pcplus1     <= '0;
            out_rs1_val     <= '0;
            out_rs2_val     <= '0;
            out_imm         <= '0;
            out_rd          <= '0;
            out_rs1         <= '0;
            out_rs2         <= '0;
            out_opclass     <= '0;
            out_funct3      <= '0;
            out_funct7      <= '0;
            out_illegal     <= 1'b0;
            out_syscall     <= 1'b0;
            out_stall_count <= '0;
        end else if (in_flush) begin
            out_valid <= 1'b0;
        end else if (in_next_ready) begin
            if (hazard) begin
                out_valid <= 1'b0;
                if (out_stall_count != '1) begin
                    out_stall_count <= out_stall_count + 32'd1;
                end
            end else if (!in_valid || (ins == '0)) begin
                out_valid <= 1'b0;
            end else begin
                out_valid   <= 1'b1;
                out_pc      <= in_pcplus1 - ADDRESS_WIDTH'(4);
                out_pcplus1 <= in_pcplus1;
                out_rs1_val <= (dec_rs1 == 5'd0) ? '0 : in_rs1_data;
                out_rs2_val <= (dec_rs2 == 5'd0) ? '0 : in_rs2_data;
                out_imm     <= dec_imm;
                out_rd      <= ins[11:7];
                out_rs1     <= dec_rs1;
                out_rs2     <= dec_rs2;
                out_opclass <= dec_opclass;
                out_funct3  <= ins[14:12];
                out_funct7  <= ins[31:25];
                out_illegal <= (dec_opclass == OPC_ILLEGAL);
                out_syscall <= (ins == INSTRUCTION_WIDTH'(32'h0000_0073));
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (both DECODE_LOADUSE_EN builds).
module tb_decode_stage;

`ifdef DECODE_LOADUSE_EN
    localparam bit LU = 1'b1;
`else
    localparam bit LU = 1'b0;
`endif

    localparam logic [31:0] I_ADDI  = 32'hFFF1_0093;
    localparam logic [31:0] I_BEQ   = 32'hFE00_0EE3;
    localparam logic [31:0] I_LD    = 32'h0003_3283;
    localparam logic [31:0] I_ADD   = 32'h0012_83B3;
    localparam logic [31:0] I_ECALL = 32'h0000_0073;
    localparam logic [31:0] I_BAD   = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instruction_bits;
    logic [63:0] in_pcplus1;
    logic        in_flush;
    logic        in_next_ready;
    logic        out_fetch_enable;
    logic [4:0]  out_rs1_addr, out_rs2_addr;
    logic [63:0] in_rs1_data, in_rs2_data;
    logic        out_valid;
    logic [63:0] out_pc, out_pcplus1, out_rs1_val, out_rs2_val, out_imm;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [3:0]  out_opclass;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic        out_illegal, out_syscall;
    logic [31:0] out_stall_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_count = 32'd0;

    decode_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .in_instruction_bits(in_instruction_bits), .in_pcplus1(in_pcplus1),
        .in_flush(in_flush), .in_next_ready(in_next_ready),
        .out_fetch_enable(out_fetch_enable),
        .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_pcplus1(out_pcplus1),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_opclass(out_opclass), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_illegal(out_illegal), .out_syscall(out_syscall),
        .out_stall_count(out_stall_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] b, input logic [63:0] pc4,
                         input logic [63:0] d1, input logic [63:0] d2);
        in_valid            = v;
        in_instruction_bits = b;
        in_pcplus1          = pc4;
        in_rs1_data         = d1;
        in_rs2_data         = d2;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_flush = 1'b0; in_next_ready = 1'b1;
        drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h want 0", out_valid); end
        checks++; if (out_stall_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0h want 0", out_stall_count); end
        checks++; if (out_imm !== 64'd0 || out_pc !== 64'd0) begin errors++; $display("FAIL reset_fields: imm %0h pc %0h want 0", out_imm, out_pc); end
        reset = 1'b0;
    endtask

    task automatic test_addi();
        drive(1'b1, I_ADDI, 64'h2004, 64'd5, 64'h99);
        checks++; if (out_rs1_addr !== 5'd2 || out_rs2_addr !== 5'd31) begin errors++; $display("FAIL addi_addr: got %0d/%0d want 2/31", out_rs1_addr, out_rs2_addr); end
        checks++; if (out_fetch_enable !== 1'b1) begin errors++; $display("FAIL addi_fetch_en: got %0h want 1", out_fetch_enable); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_opclass !== 4'd8) begin errors++; $display("FAIL addi_class: valid %0h class %0d want 1/8", out_valid, out_opclass); end
        checks++; if (out_rd !== 5'd1 || out_rs1 !== 5'd2) begin errors++; $display("FAIL addi_regs: rd %0d rs1 %0d want 1/2", out_rd, out_rs1); end
        checks++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL addi_imm: got %0h want ffffffffffffffff", out_imm); end
        checks++; if (out_rs1_val !== 64'd5 || out_pc !== 64'h2000) begin errors++; $display("FAIL addi_val_pc: val %0h pc %0h want 5/2000", out_rs1_val, out_pc); end
    endtask

    task automatic test_branch();
        drive(1'b1, I_BEQ, 64'h1004, 64'hDEAD, 64'hDEAD);
        tick();
        checks++; if (out_opclass !== 4'd5) begin errors++; $display("FAIL beq_class: got %0d want 5", out_opclass); end
        checks++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL beq_imm: got %0h want fffffffffffffffc", out_imm); end
        checks++; if (out_pc !== 64'h1000 || out_pcplus1 !== 64'h1004) begin errors++; $display("FAIL beq_pc: pc %0h pc4 %0h want 1000/1004", out_pc, out_pcplus1); end
        checks++; if (out_rs1_val !== 64'd0 || out_rs2_val !== 64'd0) begin errors++; $display("FAIL beq_x0: rs1 %0h rs2 %0h want 0/0", out_rs1_val, out_rs2_val); end
    endtask

    task automatic test_system();
        drive(1'b1, I_ECALL, 64'h3004, 64'h1, 64'h2);
        tick();
        checks++; if (out_syscall !== 1'b1 || out_opclass !== 4'd12 || out_illegal !== 1'b0) begin errors++; $display("FAIL ecall: sys %0h class %0d ill %0h want 1/12/0", out_syscall, out_opclass, out_illegal); end
        drive(1'b1, I_BAD, 64'h3008, 64'h1, 64'h2);
        tick();
        checks++; if (out_illegal !== 1'b1 || out_opclass !== 4'd0 || out_syscall !== 1'b0) begin errors++; $display("FAIL illegal: ill %0h class %0d sys %0h want 1/0/0", out_illegal, out_opclass, out_syscall); end
        checks++; if (out_imm !== 64'd0 || out_funct7 !== 7'h7F || out_rd !== 5'd31) begin errors++; $display("FAIL illegal_fields: imm %0h f7 %0h rd %0d want 0/7f/31", out_imm, out_funct7, out_rd); end
    endtask

    task automatic test_bubble();
        drive(1'b0, I_ADDI, 64'h4004, 64'd5, 64'd0);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_invalid: got %0h want 0", out_valid); end
        drive(1'b1, I_ADDI, 64'h4004, 64'd5, 64'd0);
        tick();
        drive(1'b1, 32'h0, 64'h4008, 64'd0, 64'd0);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_zero: got %0h want 0", out_valid); end
    endtask

    task automatic test_load_use();
        drive(1'b1, I_LD, 64'h5004, 64'h100, 64'h0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_opclass !== 4'd6 || out_rd !== 5'd5) begin errors++; $display("FAIL ld: valid %0h class %0d rd %0d want 1/6/5", out_valid, out_opclass, out_rd); end
        drive(1'b1, I_ADD, 64'h5008, 64'h11, 64'h22);
        checks++; if (out_fetch_enable !== !LU) begin errors++; $display("FAIL lu_fetch_en: got %0h want %0h", out_fetch_enable, !LU); end
        tick();
        exp_count = exp_count + 32'(LU);
        checks++; if (out_valid !== !LU) begin errors++; $display("FAIL lu_bubble: valid %0h want %0h", out_valid, !LU); end
        checks++; if (out_stall_count !== exp_count) begin errors++; $display("FAIL lu_count: got %0d want %0d", out_stall_count, exp_count); end
        checks++; if (out_fetch_enable !== 1'b1) begin errors++; $display("FAIL lu_fetch_release: got %0h want 1", out_fetch_enable); end
        if (LU) tick();
        checks++; if (out_valid !== 1'b1 || out_opclass !== 4'd9 || out_rd !== 5'd7) begin errors++; $display("FAIL add: valid %0h class %0d rd %0d want 1/9/7", out_valid, out_opclass, out_rd); end
        checks++; if (out_rs1 !== 5'd5 || out_rs2 !== 5'd1 || out_rs1_val !== 64'h11 || out_rs2_val !== 64'h22) begin errors++; $display("FAIL add_ops: rs %0d/%0d val %0h/%0h want 5/1 11/22", out_rs1, out_rs2, out_rs1_val, out_rs2_val); end
        checks++; if (out_stall_count !== exp_count) begin errors++; $display("FAIL add_count: got %0d want %0d", out_stall_count, exp_count); end
    endtask

    task automatic test_flush();
        drive(1'b1, I_LD, 64'h6004, 64'h100, 64'h0);
        tick();
        in_flush = 1'b1;
        drive(1'b1, I_ADD, 64'h6008, 64'h11, 64'h22);
        checks++; if (out_fetch_enable !== 1'b0) begin errors++; $display("FAIL flush_fetch_en: got %0h want 0", out_fetch_enable); end
        tick();
        in_flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_stall_count !== exp_count) begin errors++; $display("FAIL flush: valid %0h count %0d want 0/%0d", out_valid, out_stall_count, exp_count); end
        checks++; if (out_rd !== 5'd5 || out_opclass !== 4'd6) begin errors++; $display("FAIL flush_hold: rd %0d class %0d want 5/6", out_rd, out_opclass); end
    endtask

    task automatic test_stall();
        drive(1'b1, I_ADDI, 64'h7004, 64'd5, 64'd0);
        tick();
        in_next_ready = 1'b0;
        drive(1'b1, I_ECALL, 64'h7008, 64'd9, 64'd9);
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_fetch_enable !== 1'b0) begin errors++; $display("FAIL stall_fetch_en%0d: got %0h want 0", i, out_fetch_enable); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_opclass !== 4'd8 || out_imm !== 64'hFFFF_FFFF_FFFF_FFFF || out_pc !== 64'h7000) begin errors++; $display("FAIL stall_hold%0d: valid %0h class %0d imm %0h pc %0h", i, out_valid, out_opclass, out_imm, out_pc); end
            checks++; if (out_stall_count !== exp_count) begin errors++; $display("FAIL stall_count%0d: got %0d want %0d", i, out_stall_count, exp_count); end
        end
        in_next_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, I_LD, 64'h8004, 64'h100, 64'h0);
            tick();
            drive(1'b1, I_ADD, 64'h8008, 64'h11, 64'h22);
            tick();
            tick();
            exp_count = exp_count + 32'(LU);
        end
        drive(1'b1, I_ADDI, 64'h9004, 64'd5, 64'd0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_stall_count !== 32'(LU ? 7 : 0)) begin errors++; $display("FAIL pre_reset: valid %0h count %0d want 1/%0d", out_valid, out_stall_count, LU ? 7 : 0); end
        reset = 1'b1;
        tick();
        checks++; if ({out_valid, out_pc, out_pcplus1, out_rs1_val, out_rs2_val, out_imm, out_rd, out_rs1, out_rs2,
                       out_opclass, out_funct3, out_funct7, out_illegal, out_syscall, out_stall_count} !== '0) begin
            errors++; $display("FAIL mid_reset: valid %0h pc %0h imm %0h class %0d count %0d want all 0", out_valid, out_pc, out_imm, out_opclass, out_stall_count);
        end
        checks++; if (out_fetch_enable !== 1'b1) begin errors++; $display("FAIL mid_reset_fetch_en: got %0h want 1", out_fetch_enable); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_branch();
        test_system();
        test_bubble();
        test_load_use();
        test_flush();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
